// File: rtl/alu_op_arbiter_if.sv
// Request, ALU and response bundle for alu_op_arbiter; the slave modport is the arbiter's
// view and the master modport is the requester/ALU/consumer environment's view.
interface alu_op_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 3,
   parameter int N_REQ  = 4,
   parameter int ID_W   = 2
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ*SEL_W-1:0]  req_op;
   logic [N_REQ*DATA_W-1:0] req_a;
   logic [N_REQ*DATA_W-1:0] req_b;
   logic [DATA_W-1:0]       alu_a;
   logic [DATA_W-1:0]       alu_b;
   logic [SEL_W-1:0]        alu_sel;
   logic [DATA_W-1:0]       alu_y;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [ID_W-1:0]         rsp_id;
   logic [DATA_W-1:0]       rsp_data;
   logic                    busy;

   modport slave (
      input  req_valid, req_op, req_a, req_b, alu_y, rsp_ready,
      output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_data, busy
   );

   modport master (
      output req_valid, req_op, req_a, req_b, alu_y, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_data, busy
   );
endinterface

// File: rtl/alu_op_arbiter.sv
// Shares one ALU among four requesters: grant, issue registered operands, capture result,
// return it with the owner id. Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module alu_op_arbiter #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 3,
   parameter int N_REQ  = 4,
   parameter int ID_W   = 2
) (
   input logic             clk,
   input logic             rst,
   alu_op_arbiter_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]        state_r;
   logic [DATA_W-1:0] alu_a_r;
   logic [DATA_W-1:0] alu_b_r;
   logic [SEL_W-1:0]  alu_sel_r;
   logic [DATA_W-1:0] rsp_data_r;
   logic [ID_W-1:0]   rsp_id_r;
   logic              rsp_valid_r;
   logic [ID_W-1:0]   prio_base_s;
   logic [ID_W-1:0]   grant_id_s;
   logic              grant_found_s;
   logic              rsp_done_s;
   logic [N_REQ-1:0]  req_ready_s;

   assign rsp_done_s = (state_r == ST_RESP) && rsp_valid_r && bus.rsp_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign prio_base_s = {ID_W{1'b0}};
`else
   logic [ID_W-1:0] ptr_r;

   // Round-robin pointer advances past the served requester once its response completes
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= {ID_W{1'b0}};
      end else if (rsp_done_s) begin
         ptr_r <= rsp_id_r + {{(ID_W-1){1'b0}}, 1'b1};
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign prio_base_s = ptr_r;
`endif

   // Scan from the priority base (mod N_REQ) and keep the first valid requester
   always_comb begin
      grant_found_s = 1'b0;
      grant_id_s    = {ID_W{1'b0}};
      for (int k = 0; k < N_REQ; k++) begin
         grant_id_s    = (!grant_found_s && bus.req_valid[prio_base_s + ID_W'(k)]) ?
                         (prio_base_s + ID_W'(k)) : grant_id_s;
         grant_found_s = grant_found_s | bus.req_valid[prio_base_s + ID_W'(k)];
      end
   end

   // One-hot accept only in IDLE; reset suppresses any grant
   always_comb begin
      req_ready_s = {N_REQ{1'b0}};
      if (!rst && (state_r == ST_IDLE) && grant_found_s) begin
         req_ready_s[grant_id_s] = 1'b1;
      end else begin
         req_ready_s = {N_REQ{1'b0}};
      end
   end

   // Operation sequencer: issue operands, capture ALU result, hold response until taken
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         alu_a_r     <= {DATA_W{1'b0}};
         alu_b_r     <= {DATA_W{1'b0}};
         alu_sel_r   <= {SEL_W{1'b0}};
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= {ID_W{1'b0}};
         rsp_data_r  <= {DATA_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_found_s) begin
                  alu_a_r   <= bus.req_a[grant_id_s*DATA_W +: DATA_W];
                  alu_b_r   <= bus.req_b[grant_id_s*DATA_W +: DATA_W];
                  alu_sel_r <= bus.req_op[grant_id_s*SEL_W +: SEL_W];
                  rsp_id_r  <= grant_id_s;
                  state_r   <= ST_EXEC;
               end else begin
                  state_r   <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               rsp_data_r  <= bus.alu_y;
               rsp_valid_r <= 1'b1;
               state_r     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_done_s) begin
                  rsp_valid_r <= 1'b0;
                  state_r     <= ST_IDLE;
               end else begin
                  state_r     <= ST_RESP;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.alu_a     = alu_a_r;
   assign bus.alu_b     = alu_b_r;
   assign bus.alu_sel   = alu_sel_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_id    = rsp_id_r;
   assign bus.rsp_data  = rsp_data_r;
   assign bus.busy      = (state_r != ST_IDLE);
endmodule

// File: tb/tb_alu_op_arbiter.sv
// Scoreboard bench for alu_op_arbiter: grants push expected responses, a monitor pops and
// compares on every response handshake. Honours ALU_ARB_FIXED_PRIO_EN for grant orders.
module tb_alu_op_arbiter;
   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc_cnt  = 0;

   logic [9:0] exp_q[$];
   int         grant_log[$];
   int         grant_cyc[$];

   alu_op_arbiter_if bus ();

   alu_op_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference ALU: add, sub, and, or, xor, not-a, shl-a, pass-b
   function automatic logic [7:0] alu_model(input logic [2:0] sel, input logic [7:0] a,
                                            input logic [7:0] b);
      case (sel)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~a;
         3'd6:    return {a[6:0], 1'b0};
         default: return b;
      endcase
   endfunction

   assign bus.alu_y = alu_model(bus.alu_sel, bus.alu_a, bus.alu_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Grant watcher: each accepted request pushes its expected response
   always @(negedge clk) begin
      #1;
      for (int i = 0; i < 4; i++) begin
         if (bus.req_ready[i]) begin
            grant_log.push_back(i);
            grant_cyc.push_back(cyc_cnt);
            exp_q.push_back({2'(i), alu_model(bus.req_op[i*3 +: 3], bus.req_a[i*8 +: 8],
                                              bus.req_b[i*8 +: 8])});
         end
      end
   end

   // Response monitor: compare on every handshake
   always @(negedge clk) begin
      logic [9:0] e;
      #3;
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected: got id=%0d data=%0h, expected no response",
                     bus.rsp_id, bus.rsp_data);
         end else begin
            e = exp_q.pop_front();
            check("rsp_id", 32'(bus.rsp_id), 32'(e[9:8]));
            check("rsp_data", 32'(bus.rsp_data), 32'(e[7:0]));
         end
      end
   end

   task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b);
      bus.req_op[i*3 +: 3] = op;
      bus.req_a[i*8 +: 8]  = a;
      bus.req_b[i*8 +: 8]  = b;
   endtask

   task automatic wait_grants(input int n, input int budget);
      int waited = 0;
      while (grant_log.size() < n && waited < budget) begin
         @(negedge clk);
         #2;
         waited++;
      end
      check("grant_count", 32'(grant_log.size()), 32'(n));
      @(negedge clk);
      bus.req_valid = 4'b0000;
   endtask

   task automatic drain();
      int waited = 0;
      while (bus.busy && waited < 12) begin
         @(negedge clk);
         #2;
         waited++;
      end
      check("drain_idle", 32'(bus.busy), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_alu_a"}, 32'(bus.alu_a), 32'd0);
      check({tag, "_alu_b"}, 32'(bus.alu_b), 32'd0);
      check({tag, "_alu_sel"}, 32'(bus.alu_sel), 32'd0);
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
      check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rr_exp[5];
      int wrap_exp[2];
`ifdef ALU_ARB_FIXED_PRIO_EN
      rr_exp   = '{0, 0, 0, 0, 0};
      wrap_exp = '{0, 0};
`else
      rr_exp   = '{0, 1, 2, 3, 0};
      wrap_exp = '{3, 0};
`endif
      rst           = 1'b1;
      bus.req_valid = 4'b0000;
      bus.req_op    = 12'h000;
      bus.req_a     = 32'h0;
      bus.req_b     = 32'h0;
      bus.rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      check_reset_outputs("reset");

      // Reset wins over a simultaneous request
      set_req(0, 3'd1, 8'h12, 8'h34);
      bus.req_valid = 4'b1111;
      #1;
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      rst           = 1'b0;
      bus.req_valid = 4'b0000;
      #2;
      check("rst_no_grant_alu_a", 32'(bus.alu_a), 32'd0);
      check("rst_no_grant_busy", 32'(bus.busy), 32'd0);

      // Single request from requester 2: 0x5A | 0x0F = 0x5F
      @(negedge clk);
      grant_log.delete();
      grant_cyc.delete();
      set_req(2, 3'd3, 8'h5A, 8'h0F);
      bus.req_valid = 4'b0100;
      #2;
      check("single_req_ready", 32'(bus.req_ready), 32'h4);
      @(negedge clk);
      bus.req_valid = 4'b0000;
      #2;
      check("single_alu_sel", 32'(bus.alu_sel), 32'd3);
      check("single_alu_a", 32'(bus.alu_a), 32'h5A);
      check("single_alu_b", 32'(bus.alu_b), 32'h0F);
      check("single_exec_busy", 32'(bus.busy), 32'd1);
      check("single_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      #2;
      check("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("single_rsp_id", 32'(bus.rsp_id), 32'd2);
      check("single_rsp_data", 32'(bus.rsp_data), 32'h5F);
      @(negedge clk);
      #2;
      check("single_done_valid", 32'(bus.rsp_valid), 32'd0);
      check("single_done_busy", 32'(bus.busy), 32'd0);

      // Wrap: pointer sits at 3, only requesters 0 and 3 valid
      @(negedge clk);
      grant_log.delete();
      set_req(0, 3'd0, 8'h10, 8'h20);
      set_req(3, 3'd1, 8'h50, 8'h08);
      bus.req_valid = 4'b1001;
      wait_grants(2, 20);
      drain();
      for (int i = 0; i < 2; i++) check("wrap_order", 32'(grant_log[i]), 32'(wrap_exp[i]));

      // Round-robin from reset with all four requesters held valid
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      grant_log.delete();
      grant_cyc.delete();
      set_req(0, 3'd0, 8'h11, 8'h22);
      set_req(1, 3'd1, 8'h40, 8'h01);
      set_req(2, 3'd2, 8'hF0, 8'h3C);
      set_req(3, 3'd5, 8'h0F, 8'h00);
      bus.req_valid = 4'b1111;
      wait_grants(5, 30);
      drain();
      for (int i = 0; i < 5; i++) check("rr_order", 32'(grant_log[i]), 32'(rr_exp[i]));
      for (int i = 1; i < 5; i++) check("rr_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd3);

      // Backpressure: response held for 5 cycles while requester 1 stays valid
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      set_req(1, 3'd4, 8'hF0, 8'h3C);
      bus.req_valid = 4'b0010;
      #2;
      check("bp_req_ready", 32'(bus.req_ready), 32'h2);
      @(negedge clk);
      #2;
      check("bp_exec_busy", 32'(bus.busy), 32'd1);
      repeat (5) begin
         @(negedge clk);
         #2;
         check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check("bp_rsp_id", 32'(bus.rsp_id), 32'd1);
         check("bp_rsp_data", 32'(bus.rsp_data), 32'hCC);
         check("bp_req_ready_blocked", 32'(bus.req_ready), 32'd0);
      end
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      #2;
      check("bp_release_valid", 32'(bus.rsp_valid), 32'd1);
      @(negedge clk);
      bus.req_valid = 4'b0000;
      #2;
      check("bp_done_valid", 32'(bus.rsp_valid), 32'd0);
      check("bp_done_busy", 32'(bus.busy), 32'd0);

      // Reset during EXEC drops the operation and the pointer
      @(negedge clk);
      set_req(0, 3'd2, 8'hAA, 8'h0F);
      bus.req_valid = 4'b0001;
      @(negedge clk);
      bus.req_valid = 4'b0000;
      #2;
      check("midrst_exec_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      #2;
      check_reset_outputs("midrst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #2;
      check("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      grant_log.delete();
      set_req(1, 3'd0, 8'h01, 8'h02);
      set_req(3, 3'd1, 8'h09, 8'h0A);
      bus.req_valid = 4'b1010;
      #2;
      check("midrst_ptr0_ready", 32'(bus.req_ready), 32'h2);
      wait_grants(1, 10);
      drain();

      // Idle hold after a 0xFF / 0x01 / op 7 operation
      @(negedge clk);
      set_req(2, 3'd7, 8'hFF, 8'h01);
      bus.req_valid = 4'b0100;
      @(negedge clk);
      bus.req_valid = 4'b0000;
      drain();
      repeat (10) begin
         @(negedge clk);
         #2;
         check("hold_alu_a", 32'(bus.alu_a), 32'hFF);
         check("hold_alu_b", 32'(bus.alu_b), 32'h01);
         check("hold_alu_sel", 32'(bus.alu_sel), 32'd7);
         check("hold_busy", 32'(bus.busy), 32'd0);
      end

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
